// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the next-PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_RACK = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Branch opcode fields, each compared against the top bits of instr
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [21:0] OP_BR    = 22'b1101011000011111000000;

  // B.cond condition codes (instr[3:0])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  localparam logic [63:0] RESET_VEC_DEF = 64'h0;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a B.cond condition code against the NZCV flags.
module branch_cond_eval
  import pc_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken
);

  // Carry is part of the flag interface but no supported code reads it
  logic unused_c;
  assign unused_c = c;

  // Decode condition; unsupported codes are never taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: branch decode, boot/stall/halt/redirect sequencing
// and a saturating taken-branch counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VEC = RESET_VEC_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [63:0]      pc_cur,
  input  logic             rt_zero,
  input  logic [63:0]      rn_val,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_v,
  input  logic             stall,
  input  logic             halt,
  input  logic             redir_req,
  input  logic [63:0]      redir_addr,
  output logic             redir_ack,
  output logic             BrTaken,
  output logic             UncondBr,
  output logic [18:0]      CondAddr19,
  output logic [25:0]      BrAddr26,
  output logic             pc_rd,
  output logic [63:0]      pc_ext,
  output logic             halted,
  output logic [CNT_W-1:0] br_count
);

  state_t state;
  state_t next_state;
  logic   cond_taken;
  logic   taken_evt;
  logic   is_b, is_cbz, is_bcond, is_br;

  assign CondAddr19 = instr[23:5];
  assign BrAddr26   = instr[25:0];
  assign halted     = (state == ST_HALT);

  assign is_b     = (instr[31:26] == OP_B);
  assign is_cbz   = (instr[31:24] == OP_CBZ);
  assign is_bcond = (instr[31:24] == OP_BCOND);
  assign is_br    = (instr[31:10] == OP_BR) && (instr[4:0] == 5'd0);

  branch_cond_eval u_cond (
    .cond  (instr[3:0]),
    .n     (flag_n),
    .z     (flag_z),
    .c     (flag_c),
    .v     (flag_v),
    .taken (cond_taken)
  );

  // Priority mux for PC controls and next state; default is sequential PC+4
  always_comb begin
    BrTaken    = 1'b0;
    UncondBr   = 1'b0;
    pc_rd      = 1'b0;
    pc_ext     = pc_cur;
    next_state = state;
    taken_evt  = 1'b0;
    if (reset) begin
      pc_ext     = RESET_VEC;
      next_state = ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: begin
          pc_rd      = 1'b1;
          pc_ext     = RESET_VEC;
          next_state = ST_RUN;
        end
        ST_RUN: begin
          if (redir_req) begin
            pc_rd      = 1'b1;
            pc_ext     = redir_addr;
            next_state = ST_RACK;
          end else if (stall) begin
            pc_rd = 1'b1;
          end else if (halt) begin
            pc_rd      = 1'b1;
            next_state = ST_HALT;
          end else if (!instr_valid) begin
            pc_rd = 1'b1;
          end else if (is_b) begin
            BrTaken   = 1'b1;
            UncondBr  = 1'b1;
            taken_evt = 1'b1;
          end else if (is_cbz) begin
            BrTaken   = rt_zero;
            taken_evt = rt_zero;
          end else if (is_bcond) begin
            BrTaken   = cond_taken;
            taken_evt = cond_taken;
          end else if (is_br) begin
            pc_rd     = 1'b1;
            pc_ext    = rn_val;
            taken_evt = 1'b1;
          end
        end
        // Requester sees the ack this cycle; its still-high request is ignored
        ST_RACK: begin
          pc_rd      = 1'b1;
          next_state = ST_RUN;
        end
        ST_HALT: begin
          if (redir_req) begin
            pc_rd      = 1'b1;
            pc_ext     = redir_addr;
            next_state = ST_RACK;
          end else begin
            pc_rd = 1'b1;
          end
        end
        default: begin
          next_state = ST_BOOT;
        end
      endcase
    end
  end

  // State register, registered ack pulse and saturating taken-branch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BOOT;
      redir_ack <= 1'b0;
      br_count  <= '0;
    end else begin
      state     <= next_state;
      redir_ack <= (next_state == ST_RACK);
      if (taken_evt && (br_count != {CNT_W{1'b1}})) begin
        br_count <= br_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench: pc_sequencer driving a behavioural program counter, with a
// scoreboard of expected PC / branch count after each clock edge.
module tb_pc_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [63:0]      pc;
  logic             rt_zero;
  logic [63:0]      rn_val;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             stall, halt, redir_req;
  logic [63:0]      redir_addr;
  logic             redir_ack, BrTaken, UncondBr, pc_rd, halted;
  logic [18:0]      CondAddr19;
  logic [25:0]      BrAddr26;
  logic [63:0]      pc_ext;
  logic [CNT_W-1:0] br_count;

  typedef struct {
    logic [63:0]      epc;
    logic [CNT_W-1:0] ecnt;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e;
  int               checks = 0;
  int               failures = 0;
  logic [63:0]      exp_pc;
  logic [CNT_W-1:0] exp_cnt;

  localparam logic [31:0] NOP = 32'hD503201F;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VEC(64'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .pc_cur(pc), .rt_zero(rt_zero), .rn_val(rn_val),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .stall(stall), .halt(halt), .redir_req(redir_req), .redir_addr(redir_addr),
    .redir_ack(redir_ack), .BrTaken(BrTaken), .UncondBr(UncondBr),
    .CondAddr19(CondAddr19), .BrAddr26(BrAddr26), .pc_rd(pc_rd),
    .pc_ext(pc_ext), .halted(halted), .br_count(br_count)
  );

  // Program counter: load, PC+offset, or PC+4
  always_ff @(posedge clk) begin
    if (pc_rd) pc <= pc_ext;
    else if (BrTaken)
      pc <= pc + (UncondBr ? {{36{BrAddr26[25]}}, BrAddr26, 2'b00}
                           : {{43{CondAddr19[18]}}, CondAddr19, 2'b00});
    else pc <= pc + 64'd4;
  end

  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] imm);
    return {8'b10110100, imm, 5'd0};
  endfunction
  function automatic logic [31:0] enc_bcond(input logic [18:0] imm, input logic [3:0] cc);
    return {8'b01010100, imm, 1'b0, cc};
  endfunction
  function automatic logic [31:0] enc_br(input logic [4:0] rn);
    return {22'b1101011000011111000000, rn, 5'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = NOP; rt_zero = 1'b0; rn_val = '0;
    flag_n = 0; flag_z = 0; flag_c = 0; flag_v = 0;
    stall = 0; halt = 0; redir_req = 0; redir_addr = '0;
    tick(); tick();
    checks++;
    if (pc_rd !== 1'b0 || BrTaken !== 1'b0 || UncondBr !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got pc_rd=%b BrTaken=%b UncondBr=%b want 000", pc_rd, BrTaken, UncondBr);
    end
    checks++;
    if (pc_ext !== 64'h0 || br_count !== '0 || redir_ack !== 1'b0) begin
      failures++; $display("FAIL reset_vals got pc_ext=%0h cnt=%0d ack=%b want 0 0 0", pc_ext, br_count, redir_ack);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pc_rd !== 1'b1 || pc_ext !== 64'h0) begin
      failures++; $display("FAIL boot_load got pc_rd=%b pc_ext=%0h want 1 0", pc_rd, pc_ext);
    end
    exp_pc = 64'h0; exp_cnt = '0;
    exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc) begin failures++; $display("FAIL boot_pc got %0h want %0h", pc, e.epc); end
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_pc + 64'd4;
      exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL seq_pc got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
      end
    end
  endtask

  task automatic test_branch_b();
    instr = enc_b(26'd3);
    #1;
    checks++;
    if (BrTaken !== 1'b1 || UncondBr !== 1'b1 || BrAddr26 !== 26'd3) begin
      failures++; $display("FAIL b_ctrl got BrTaken=%b UncondBr=%b imm=%0d want 1 1 3", BrTaken, UncondBr, BrAddr26);
    end
    exp_pc = 64'h1C; exp_cnt = 4'd1;
    exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc || br_count !== e.ecnt) begin
      failures++; $display("FAIL b_target got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
    end
  endtask

  task automatic test_cond();
    logic [31:0] ins [6];
    logic        rz  [6];
    logic [2:0]  nzv [6];
    logic        tk  [6];
    logic [63:0] npc [6];
    ins[0] = enc_cbz(19'h7FFFE);       rz[0] = 0; nzv[0] = 3'b000; tk[0] = 0; npc[0] = 64'h20;
    ins[1] = enc_cbz(19'h7FFFE);       rz[1] = 1; nzv[1] = 3'b000; tk[1] = 1; npc[1] = 64'h18;
    ins[2] = enc_bcond(19'd2, 4'hB);   rz[2] = 0; nzv[2] = 3'b100; tk[2] = 1; npc[2] = 64'h20;
    ins[3] = enc_bcond(19'd2, 4'hC);   rz[3] = 0; nzv[3] = 3'b010; tk[3] = 0; npc[3] = 64'h24;
    ins[4] = enc_bcond(19'd2, 4'h2);   rz[4] = 0; nzv[4] = 3'b010; tk[4] = 0; npc[4] = 64'h28;
    ins[5] = enc_bcond(19'd2, 4'h0);   rz[5] = 0; nzv[5] = 3'b010; tk[5] = 1; npc[5] = 64'h30;
    for (int i = 0; i < 6; i++) begin
      instr = ins[i]; rt_zero = rz[i];
      {flag_n, flag_z, flag_v} = nzv[i];
      #1;
      checks++;
      if (BrTaken !== tk[i] || UncondBr !== 1'b0) begin
        failures++; $display("FAIL cond_ctrl[%0d] got BrTaken=%b UncondBr=%b want %b 0", i, BrTaken, UncondBr, tk[i]);
      end
      if (tk[i]) exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back('{epc: npc[i], ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL cond_pc[%0d] got pc=%0h cnt=%0d want %0h %0d", i, pc, br_count, e.epc, e.ecnt);
      end
    end
    rt_zero = 0; flag_n = 0; flag_z = 0; flag_v = 0;
    rn_val = 64'h34; instr = enc_br(5'd3);
    #1;
    checks++;
    if (pc_rd !== 1'b1 || pc_ext !== 64'h34 || BrTaken !== 1'b0) begin
      failures++; $display("FAIL br_ctrl got pc_rd=%b pc_ext=%0h BrTaken=%b want 1 34 0", pc_rd, pc_ext, BrTaken);
    end
    exp_pc = 64'h34; exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc || br_count !== e.ecnt) begin
      failures++; $display("FAIL br_pc got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
    end
    instr = NOP;
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_pc + 64'd4;
      exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL walk_pc got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; instr = enc_b(26'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (BrTaken !== 1'b0 || pc_rd !== 1'b1) begin
        failures++; $display("FAIL stall_ctrl got BrTaken=%b pc_rd=%b want 0 1", BrTaken, pc_rd);
      end
      exp_q.push_back('{epc: 64'h40, ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL stall_pc got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
      end
    end
  endtask

  task automatic test_redirect();
    redir_req = 1'b1; redir_addr = 64'hB302;
    #1;
    checks++;
    if (pc_rd !== 1'b1 || pc_ext !== 64'hB302) begin
      failures++; $display("FAIL redir_ctrl got pc_rd=%b pc_ext=%0h want 1 b302", pc_rd, pc_ext);
    end
    exp_q.push_back('{epc: 64'hB302, ecnt: exp_cnt});
    exp_q.push_back('{epc: 64'hB302, ecnt: exp_cnt});
    exp_q.push_back('{epc: 64'hB306, ecnt: exp_cnt});
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin redir_req = 1'b0; stall = 1'b0; instr = NOP; end
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL redir_pc[%0d] got pc=%0h cnt=%0d want %0h %0d", i, pc, br_count, e.epc, e.ecnt);
      end
      checks++;
      if (redir_ack !== (i == 0)) begin
        failures++; $display("FAIL redir_ack[%0d] got %b want %b", i, redir_ack, (i == 0));
      end
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    exp_q.push_back('{epc: 64'hB306, ecnt: exp_cnt});
    tick();
    halt = 1'b0; instr = enc_b(26'd3);
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc || halted !== 1'b1) begin
      failures++; $display("FAIL halt_enter got pc=%0h halted=%b want %0h 1", pc, halted, e.epc);
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{epc: 64'hB306, ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt || halted !== 1'b1) begin
        failures++; $display("FAIL halt_hold got pc=%0h cnt=%0d halted=%b want %0h %0d 1", pc, br_count, halted, e.epc, e.ecnt);
      end
    end
    redir_req = 1'b1; redir_addr = 64'h100; instr = NOP;
    exp_q.push_back('{epc: 64'h100, ecnt: exp_cnt});
    tick();
    redir_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc || redir_ack !== 1'b1 || halted !== 1'b0) begin
      failures++; $display("FAIL halt_exit got pc=%0h ack=%b halted=%b want %0h 1 0", pc, redir_ack, halted, e.epc);
    end
    exp_pc = 64'h100;
    exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
    tick();
    e = exp_q.pop_front();
    checks++;
    if (pc !== e.epc) begin failures++; $display("FAIL rack_hold got pc=%0h want %0h", pc, e.epc); end
  endtask

  task automatic test_back_to_back();
    instr = enc_b(26'd1);
    for (int i = 0; i < 13; i++) begin
      exp_pc = exp_pc + 64'd4;
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back('{epc: exp_pc, ecnt: exp_cnt});
      tick();
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.epc || br_count !== e.ecnt) begin
        failures++; $display("FAIL b2b_pc got pc=%0h cnt=%0d want %0h %0d", pc, br_count, e.epc, e.ecnt);
      end
    end
    checks++;
    if (br_count !== 4'd15) begin failures++; $display("FAIL cnt_sat got %0d want 15", br_count); end
  endtask

  task automatic test_reset_mid_redirect();
    instr = NOP; redir_req = 1'b1; redir_addr = 64'h200;
    tick();
    redir_req = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if (redir_ack !== 1'b0 || br_count !== '0 || halted !== 1'b0) begin
      failures++; $display("FAIL mid_reset got ack=%b cnt=%0d halted=%b want 0 0 0", redir_ack, br_count, halted);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch_b();
    test_cond();
    test_stall();
    test_redirect();
    test_halt();
    test_back_to_back();
    test_reset_mid_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
